// File: rtl/teleprinter_tx.sv
// Console teleprinter transmitter: decodes device-04 IOTs and sends AC[4:11] as 8N2 frames on tx.
// Latency: tx falls on the F3 edge that commits TPC/TLS; the flag sets 11*DIV clocks later.
// Backpressure: a load while a frame is in flight is dropped; software paces itself on tto_flag.

module teleprinter_tx #(
    parameter int         CLOCK_FREQ = 50000000,
    parameter int         BAUD       = 115200,
    parameter logic [4:0] F3         = 5'd3      // CPU state code of the IOT execute phase
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic [0:11] instruction,
    input  logic [0:11] ac,
    output logic        tx,
    output logic        tto_skip,
    output logic        tto_flag,
    output logic        tto_irq,
    output logic        tx_busy
);

    localparam int            DIV      = CLOCK_FREQ / BAUD;   // clocks per bit, at least 2
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP1, S_STOP2} tx_state_t;

    tx_state_t     tx_state;
    tx_state_t     tx_state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          int_enable;

    logic          iot_commit;
    logic [2:0]    iot_fn;
    logic          do_spf;
    logic          do_clear;
    logic          do_load;
    logic          do_kie;
    logic          bit_end;
    logic          frame_done;
    logic          ac_unused;

    // IOT decode: device 04 commits only in F3; KIE is the keyboard's code but also sets our enable.
    assign iot_commit = (state == F3) && (instruction[0:8] == 9'o604);
    assign iot_fn     = instruction[9:11];
    assign do_spf     = iot_commit && (iot_fn == 3'o0);
    assign do_clear   = iot_commit && ((iot_fn == 3'o2) || (iot_fn == 3'o6));
    assign do_load    = iot_commit && ((iot_fn == 3'o4) || (iot_fn == 3'o6));
    assign do_kie     = (state == F3) && (instruction == 12'o6035);

    // The upper AC bits carry nothing for the printer.
    assign ac_unused  = ^ac[0:3];

    assign bit_end    = (baud_cnt == BIT_LAST);
    assign frame_done = (tx_state == S_STOP2) && bit_end;
    assign tx_busy    = (tx_state != S_IDLE);
    assign tto_irq    = tto_flag & int_enable;

    // Skip looks only at the instruction word, never at the CPU state.
    assign tto_skip = ((instruction == 12'o6041) && tto_flag) ||
                      ((instruction == 12'o6045) && tto_flag && int_enable);

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    // Next frame state: every non-idle state lasts one baud period; DATA repeats for 8 bits.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            S_IDLE:  if (do_load) tx_state_next = S_START;
            S_START: if (bit_end) tx_state_next = S_DATA;
            S_DATA:  if (bit_end && (bit_idx == 3'd7)) tx_state_next = S_STOP1;
            S_STOP1: if (bit_end) tx_state_next = S_STOP2;
            S_STOP2: if (bit_end) tx_state_next = S_IDLE;
            default: tx_state_next = S_IDLE;
        endcase
    end

    // Baud counter, shift register and registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (do_load) begin
                        shreg   <= ac[4:11];
                        bit_idx <= '0;
                        tx      <= 1'b0;
                    end
                end
                default: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
                    if (bit_end) begin
                        case (tx_state)
                            S_START: tx <= shreg[0];
                            S_DATA: begin
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7) begin
                                    tx <= 1'b1;
                                end else begin
                                    tx    <= shreg[1];
                                    shreg <= {1'b0, shreg[7:1]};
                                end
                            end
                            default: tx <= 1'b1;
                        endcase
                    end
                end
            endcase
        end
    end

    // Printer flag and interrupt enable; completion is applied last so it beats a same-edge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tto_flag   <= 1'b0;
            int_enable <= 1'b1;
        end else begin
            if (do_clear)   tto_flag <= 1'b0;
            if (do_spf)     tto_flag <= 1'b1;
            if (frame_done) tto_flag <= 1'b1;
            if (do_kie)     int_enable <= ac[11];
        end
    end

endmodule
